// File: rtl/lfsr_stream_if.sv
// Seed-load handshake and valid/ready word stream between lfsr_stream and its host/consumer.
// The master side drives seeds, run and out_ready; the slave side is the generator.
interface lfsr_stream_if #(
    parameter int WIDTH = 64
);
    logic             seed_valid;
    logic [WIDTH-1:0] seed;
    logic             seed_ready;
    logic             run;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             seed_fixed;
    logic [31:0]      word_count;

    modport master (
        output seed_valid, seed, run, out_ready,
        input  seed_ready, out_valid, out_data, seed_fixed, word_count
    );

    modport slave (
        input  seed_valid, seed, run, out_ready,
        output seed_ready, out_valid, out_data, seed_fixed, word_count
    );
endinterface

// File: rtl/lfsr_stream.sv
// XNOR Fibonacci LFSR word generator: seed-load handshake, valid/ready output stream,
// all-ones lockup protection and a per-seed word counter.
module lfsr_stream #(
    parameter int             WIDTH = 64,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(64'hD800_0000_0000_0000),
    parameter int             STEPS = 1
) (
    input  logic        clk,
    input  logic        reset,
    lfsr_stream_if.slave bus
);

    if (WIDTH < 3 || WIDTH > 128) begin : g_bad_width
        $error("lfsr_stream: WIDTH must be in 3..128");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
        $error("lfsr_stream: TAPS[WIDTH-1] must be set");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_stream: STEPS must be in 1..WIDTH");
    end

    // Encoding is {loaded, out_valid}; 2'b01 cannot be reached.
    typedef enum logic [1:0] {
        UNSEEDED  = 2'b00,
        SEEDED    = 2'b10,
        STREAMING = 2'b11
    } fsm_t;

    fsm_t             state_q, state_d;
    logic [WIDTH-1:0] lfsr_q;
    logic             seed_fixed_q;
    logic [31:0]      count_q;
    logic             out_valid;
    logic             seed_ready;
    logic             seed_acc;
    logic             fire;
    logic             seed_all_ones;

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ~^(s & TAPS)};
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] t;
        t = s;
        for (int i = 0; i < STEPS; i++) t = shift_once(t);
        return t;
    endfunction

    assign seed_acc      = bus.seed_valid & seed_ready;
    assign fire          = out_valid & bus.out_ready;
    assign seed_all_ones = &bus.seed;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_q <= UNSEEDED;
        else       state_q <= state_d;
    end

    // A pending word is never withdrawn: while stalled, STREAMING holds regardless of run.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            UNSEEDED:  if (seed_acc)       state_d = SEEDED;
            SEEDED:    if (bus.run)        state_d = STREAMING;
            STREAMING: if (fire && !bus.run) state_d = SEEDED;
            default:                       state_d = UNSEEDED;
        endcase
    end

    always_comb begin
        out_valid  = (state_q == STREAMING);
        seed_ready = !out_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q       <= '0;
            seed_fixed_q <= 1'b0;
            count_q      <= '0;
        end else if (seed_acc) begin
            lfsr_q       <= seed_all_ones ? '0 : bus.seed;
            seed_fixed_q <= seed_all_ones;
            count_q      <= '0;
        end else if (fire) begin
            lfsr_q  <= advance(lfsr_q);
            count_q <= count_q + 32'd1;
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.seed_ready = seed_ready;
    assign bus.out_data   = lfsr_q;
    assign bus.seed_fixed = seed_fixed_q;
    assign bus.word_count = count_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboard bench for lfsr_stream: three configurations (4-bit x1, 4-bit x2, 64-bit default)
// with hand-computed word sequences checked by per-instance monitors.
module tb_lfsr_stream;

    typedef struct {
        logic [63:0] data;
        logic [31:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    logic [3:0] seq_a [16] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                               4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
    logic [3:0] seq_b [6]  = '{4'h0, 4'h3, 4'hE, 4'hB, 4'hC, 4'h2};
    logic [3:0] seq_r [7]  = '{4'h5, 4'hA, 4'h4, 4'h8, 4'h0, 4'h1, 4'h3};

    always #5 clk = ~clk;

    lfsr_stream_if #(.WIDTH(4))  a_if ();
    lfsr_stream_if #(.WIDTH(4))  b_if ();
    lfsr_stream_if #(.WIDTH(64)) c_if ();

    lfsr_stream #(.WIDTH(4), .TAPS(4'b1100), .STEPS(1)) u_a (.clk(clk), .reset(reset), .bus(a_if));
    lfsr_stream #(.WIDTH(4), .TAPS(4'b1100), .STEPS(2)) u_b (.clk(clk), .reset(reset), .bus(b_if));
    lfsr_stream u_c (.clk(clk), .reset(reset), .bus(c_if));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [63:0] d, input int c);
        exp_t e;
        e.data  = d;
        e.count = 32'(c);
        case (k)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic mon(input int k, input logic [63:0] d, input logic [31:0] c);
        exp_t e;
        bit   got;
        got = 1'b0;
        case (k)
            0:       if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
            1:       if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); got = 1'b1; end
        endcase
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d unexpected word: got %0h, none expected", k, d);
        end else begin
            check($sformatf("dut%0d word%0d data", k, e.count), 128'(d), 128'(e.data));
            check($sformatf("dut%0d word%0d count", k, e.count), 128'(c), 128'(e.count));
        end
    endtask

    // Monitors: a transfer happens at the next edge only if reset is low then.
    always @(negedge clk) if (!reset && a_if.out_valid && a_if.out_ready) mon(0, 64'(a_if.out_data), a_if.word_count);
    always @(negedge clk) if (!reset && b_if.out_valid && b_if.out_ready) mon(1, 64'(b_if.out_data), b_if.word_count);
    always @(negedge clk) if (!reset && c_if.out_valid && c_if.out_ready) mon(2, c_if.out_data, c_if.word_count);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        @(negedge clk);
        check({tag, " out_valid"},  128'(a_if.out_valid),  128'(0));
        check({tag, " seed_ready"}, 128'(a_if.seed_ready), 128'(1));
        check({tag, " out_data"},   128'(a_if.out_data),   128'(0));
        check({tag, " seed_fixed"}, 128'(a_if.seed_fixed), 128'(0));
        check({tag, " word_count"}, 128'(a_if.word_count), 128'(0));
    endtask

    initial begin
        reset = 1'b1;
        a_if.seed_valid = 1'b1; a_if.seed = 4'h5; a_if.run = 1'b0; a_if.out_ready = 1'b0;
        b_if.seed_valid = 1'b0; b_if.seed = '0;   b_if.run = 1'b0; b_if.out_ready = 1'b0;
        c_if.seed_valid = 1'b0; c_if.seed = '0;   c_if.run = 1'b0; c_if.out_ready = 1'b0;
        tick;
        tick;
        check_reset_a("reset");
        check("reset c out_data", 128'(c_if.out_data), 128'(0));
        check("reset b out_valid", 128'(b_if.out_valid), 128'(0));
        reset = 1'b0;
        a_if.seed_valid = 1'b0;
        tick;
        @(negedge clk);
        check("seed during reset ignored", 128'(a_if.out_data), 128'(0));

        // Full-period run on a, STEPS=2 on b, default 64-bit on c, all in parallel.
        for (int i = 0; i < 16; i++) push(0, 64'(seq_a[i]), i);
        for (int i = 0; i < 6; i++)  push(1, 64'(seq_b[i]), i);
        push(2, 64'h1, 0); push(2, 64'h3, 1); push(2, 64'h7, 2); push(2, 64'hF, 3);
        a_if.seed_valid = 1'b1; a_if.seed = 4'h0;  a_if.run = 1'b1; a_if.out_ready = 1'b1;
        b_if.seed_valid = 1'b1; b_if.seed = 4'h0;  b_if.run = 1'b1; b_if.out_ready = 1'b1;
        c_if.seed_valid = 1'b1; c_if.seed = 64'h1; c_if.run = 1'b1; c_if.out_ready = 1'b1;
        tick;
        a_if.seed_valid = 1'b0; b_if.seed_valid = 1'b0; c_if.seed_valid = 1'b0;
        @(negedge clk);
        check("c valid one edge after accept", 128'(c_if.out_valid), 128'(0));
        check("c data is seed", 128'(c_if.out_data), 128'(64'h1));
        tick;
        @(negedge clk);
        check("c valid two edges after accept", 128'(c_if.out_valid), 128'(1));
        check("c seed_ready while valid", 128'(c_if.seed_ready), 128'(0));
        for (int e = 3; e <= 17; e++) begin
            tick;
            if (e == 5) c_if.run = 1'b0;
            if (e == 7) b_if.run = 1'b0;
        end
        a_if.run = 1'b0;
        tick;
        @(negedge clk);
        check("a drained out_valid", 128'(a_if.out_valid), 128'(0));
        check("a after 16 words data", 128'(a_if.out_data), 128'(4'h1));
        check("a after 16 words count", 128'(a_if.word_count), 128'(16));
        check("b after 6 words data", 128'(b_if.out_data), 128'(4'hA));
        check("b after 6 words count", 128'(b_if.word_count), 128'(6));
        check("c after 4 words data", 128'(c_if.out_data), 128'(64'h1F));
        check("c drained out_valid", 128'(c_if.out_valid), 128'(0));

        // All-ones seed is replaced by zero and flagged.
        push(0, 64'h0, 0); push(0, 64'h1, 1);
        a_if.seed_valid = 1'b1; a_if.seed = 4'hF;
        tick;
        a_if.seed_valid = 1'b0;
        @(negedge clk);
        check("fixed seed_fixed", 128'(a_if.seed_fixed), 128'(1));
        check("fixed data", 128'(a_if.out_data), 128'(0));
        check("fixed count reset", 128'(a_if.word_count), 128'(0));
        a_if.run = 1'b1;
        tick;
        tick;
        a_if.run = 1'b0;
        tick;
        @(negedge clk);
        check("fixed sticky", 128'(a_if.seed_fixed), 128'(1));
        check("fixed after 2 words data", 128'(a_if.out_data), 128'(4'h3));

        // Reseed with 0x5, then backpressure, then reset mid-stream after 7 words.
        for (int i = 0; i < 7; i++) push(0, 64'(seq_r[i]), i);
        a_if.seed_valid = 1'b1; a_if.seed = 4'h5;
        tick;
        a_if.seed_valid = 1'b0;
        @(negedge clk);
        check("reseed clears seed_fixed", 128'(a_if.seed_fixed), 128'(0));
        check("reseed data", 128'(a_if.out_data), 128'(4'h5));
        a_if.run = 1'b1;
        tick;
        tick;
        a_if.out_ready = 1'b0;
        a_if.seed_valid = 1'b1; a_if.seed = 4'h9;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) a_if.run = 1'b0;
            if (i == 3) a_if.run = 1'b1;
            tick;
            @(negedge clk);
            check($sformatf("stall%0d out_valid", i),  128'(a_if.out_valid),  128'(1));
            check($sformatf("stall%0d out_data", i),   128'(a_if.out_data),   128'(4'hA));
            check($sformatf("stall%0d word_count", i), 128'(a_if.word_count), 128'(1));
            check($sformatf("stall%0d seed_ready", i), 128'(a_if.seed_ready), 128'(0));
        end
        a_if.seed_valid = 1'b0;
        a_if.out_ready = 1'b1;
        a_if.run = 1'b1;
        repeat (6) tick;
        @(negedge clk);
        check("pre-reset count", 128'(a_if.word_count), 128'(7));
        reset = 1'b1;
        a_if.seed_valid = 1'b1; a_if.seed = 4'h9;
        tick;
        check_reset_a("mid-stream reset");
        reset = 1'b0;
        a_if.seed_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            @(negedge clk);
            check($sformatf("unseeded%0d out_valid", i), 128'(a_if.out_valid), 128'(0));
        end
        a_if.run = 1'b0;
        a_if.seed_valid = 1'b1; a_if.seed = 4'h3;
        tick;
        a_if.seed_valid = 1'b0;
        @(negedge clk);
        check("post-reset seed data", 128'(a_if.out_data), 128'(4'h3));
        check("post-reset out_valid", 128'(a_if.out_valid), 128'(0));

        check("a words outstanding", 128'(q_a.size()), 128'(0));
        check("b words outstanding", 128'(q_b.size()), 128'(0));
        check("c words outstanding", 128'(q_c.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
